// File: rtl/score_recorder.sv
// Records held notes into an eighth-note score, one slot per tick, and shows a frame-coherent copy.
// Optional count-in before recording is compiled in by defining SCORE_COUNT_IN_EN.
module score_recorder #(
    parameter int unsigned TICKS_PER_EIGHTH = 18562500,
    parameter int unsigned SLOTS            = 160,
    parameter int unsigned WRAP             = 0
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  stop_in,
    input  logic                  note_valid_in,
    input  logic [5:0]            note_in,
    input  logic                  new_frame_in,
    output logic [SLOTS-1:0][5:0] notes_out,
    output logic [7:0]            slot_out,
    output logic                  tick_out,
    output logic                  recording_out,
    output logic                  full_out
);

    localparam int unsigned CNT_W     = (TICKS_PER_EIGHTH > 1) ? $clog2(TICKS_PER_EIGHTH) : 1;
    localparam int unsigned SLOT_W    = 8;
    localparam int unsigned NOTE_W    = 6;
    localparam int unsigned LEAD_W    = 3;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICKS_PER_EIGHTH - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam bit                WRAP_EN   = (WRAP != 0);

`ifdef SCORE_COUNT_IN_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT_IN = 2'd1,
        RECORD   = 2'd2,
        FULL     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd2,
        FULL   = 2'd3
    } state_t;
`endif

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [NOTE_W-1:0]       held;
    logic [SLOTS-1:0][5:0]   shadow;
`ifdef SCORE_COUNT_IN_EN
    logic [LEAD_W-1:0]       lead_cnt;
`endif

    logic                    running;
    logic                    tick;
    logic                    arm;
    logic [NOTE_W-1:0]       wr_data;

    // Slot timing and start qualification; stop beats start in the same cycle.
    always_comb begin
        running = 1'b0;
        tick    = 1'b0;
        arm     = 1'b0;
        wr_data = held;
`ifdef SCORE_COUNT_IN_EN
        running = (state == RECORD) || (state == COUNT_IN);
`else
        running = (state == RECORD);
`endif
        tick    = running && (cnt == CNT_LAST);
        arm     = ((state == IDLE) || (state == FULL)) && start_in && !stop_in;
        if (note_valid_in) begin
            wr_data = note_in;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            cnt           <= '0;
            slot_out      <= '0;
            held          <= '0;
            shadow        <= '0;
            notes_out     <= '0;
            tick_out      <= 1'b0;
            recording_out <= 1'b0;
            full_out      <= 1'b0;
`ifdef SCORE_COUNT_IN_EN
            lead_cnt      <= '0;
`endif
        end else begin
            tick_out <= tick;

            // Whole-array snapshot; a coincident write lands only in the next frame.
            if (new_frame_in) begin
                notes_out <= shadow;
            end

            if (note_valid_in) begin
                held <= note_in;
            end

            if (running) begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
            end

            case (state)
                IDLE, FULL: begin
                    if (arm) begin
                        shadow   <= '0;
                        slot_out <= '0;
                        held     <= '0;
                        cnt      <= '0;
                        full_out <= 1'b0;
`ifdef SCORE_COUNT_IN_EN
                        state         <= COUNT_IN;
                        lead_cnt      <= '0;
                        recording_out <= 1'b0;
`else
                        state         <= RECORD;
                        recording_out <= 1'b1;
`endif
                    end
                end
`ifdef SCORE_COUNT_IN_EN
                COUNT_IN: begin
                    if (stop_in) begin
                        state <= IDLE;
                    end else if (tick) begin
                        lead_cnt <= lead_cnt + LEAD_W'(1);
                        if (lead_cnt == LEAD_W'(7)) begin
                            state         <= RECORD;
                            recording_out <= 1'b1;
                        end
                    end
                end
`endif
                RECORD: begin
                    if (stop_in) begin
                        state         <= IDLE;
                        recording_out <= 1'b0;
                    end else if (tick) begin
                        if (slot_out == LAST_SLOT) begin
                            if (WRAP_EN) begin
                                shadow   <= '0;
                                slot_out <= '0;
                            end else begin
                                shadow[slot_out] <= wr_data;
                                state            <= FULL;
                                recording_out    <= 1'b0;
                                full_out         <= 1'b1;
                            end
                        end else begin
                            shadow[slot_out] <= wr_data;
                            slot_out         <= slot_out + SLOT_W'(1);
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    recording_out <= 1'b0;
                    full_out      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_recorder.sv
// Bench for score_recorder: stop-at-full and wrapping instances driven in lockstep against a reference model.
`timescale 1ns/1ps
module tb_score_recorder;

    localparam int T     = 4;
    localparam int SLOTS = 160;
`ifdef SCORE_COUNT_IN_EN
    localparam bit CI_EN = 1'b1;
`else
    localparam bit CI_EN = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_LEAD = 1;
    localparam int M_REC  = 2;
    localparam int M_FULL = 3;

    logic clk = 1'b0;
    logic rst, start, stop, note_valid, new_frame;
    logic [5:0] note;

    logic [SLOTS-1:0][5:0] notes_a, notes_b;
    logic [7:0] slot_a, slot_b;
    logic tick_a, tick_b, rec_a, rec_b, full_a, full_b;

    score_recorder #(.TICKS_PER_EIGHTH(T), .SLOTS(SLOTS), .WRAP(0)) dut_stop (
        .pixel_clk_in(clk), .rst_in(rst), .start_in(start), .stop_in(stop),
        .note_valid_in(note_valid), .note_in(note), .new_frame_in(new_frame),
        .notes_out(notes_a), .slot_out(slot_a), .tick_out(tick_a),
        .recording_out(rec_a), .full_out(full_a)
    );

    score_recorder #(.TICKS_PER_EIGHTH(T), .SLOTS(SLOTS), .WRAP(1)) dut_wrap (
        .pixel_clk_in(clk), .rst_in(rst), .start_in(start), .stop_in(stop),
        .note_valid_in(note_valid), .note_in(note), .new_frame_in(new_frame),
        .notes_out(notes_b), .slot_out(slot_b), .tick_out(tick_b),
        .recording_out(rec_b), .full_out(full_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: index 0 stops when full, index 1 wraps.
    int         m_mode [2];
    int         m_el   [2];
    int         m_slot [2];
    logic [5:0] m_held [2];
    logic [5:0] m_shadow [2][SLOTS];
    logic [5:0] m_notes  [2][SLOTS];
    bit         m_tick [2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        bit running, tk;
        logic [5:0] wdata;
        if (rst) begin
            m_mode[k] = M_IDLE; m_el[k] = 0; m_slot[k] = 0; m_held[k] = '0; m_tick[k] = 0;
            for (int i = 0; i < SLOTS; i++) begin
                m_shadow[k][i] = '0;
                m_notes[k][i]  = '0;
            end
            return;
        end
        running   = (m_mode[k] == M_LEAD) || (m_mode[k] == M_REC);
        tk        = running && (((m_el[k] + 1) % T) == 0);
        m_tick[k] = tk;
        wdata     = note_valid ? note : m_held[k];
        if (new_frame)
            for (int i = 0; i < SLOTS; i++) m_notes[k][i] = m_shadow[k][i];
        if (note_valid) m_held[k] = note;
        if (running && stop) begin
            m_mode[k] = M_IDLE;
        end else if (!running && start && !stop) begin
            for (int i = 0; i < SLOTS; i++) m_shadow[k][i] = '0;
            m_slot[k] = 0; m_held[k] = '0; m_el[k] = 0;
            m_mode[k] = CI_EN ? M_LEAD : M_REC;
        end else if (m_mode[k] == M_LEAD) begin
            m_el[k]++;
            if (m_el[k] == 8 * T) begin
                m_mode[k] = M_REC;
                m_el[k]   = 0;
            end
        end else if (m_mode[k] == M_REC) begin
            m_el[k]++;
            if (tk) begin
                if (m_slot[k] == SLOTS - 1) begin
                    if (k == 1) begin
                        for (int i = 0; i < SLOTS; i++) m_shadow[k][i] = '0;
                        m_slot[k] = 0;
                    end else begin
                        m_shadow[k][m_slot[k]] = wdata;
                        m_mode[k] = M_FULL;
                    end
                end else begin
                    m_shadow[k][m_slot[k]] = wdata;
                    m_slot[k]++;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [SLOTS-1:0][5:0] dn;
        string pfx;
        int idx;
        for (int k = 0; k < 2; k++) begin
            pfx = (k == 0) ? "stop" : "wrap";
            dn  = (k == 0) ? notes_a : notes_b;
            chk({pfx, ".slot"}, int'((k == 0) ? slot_a : slot_b), m_slot[k]);
            chk({pfx, ".tick"}, int'((k == 0) ? tick_a : tick_b), int'(m_tick[k]));
            chk({pfx, ".recording"}, int'((k == 0) ? rec_a : rec_b), int'(m_mode[k] == M_REC));
            chk({pfx, ".full"}, int'((k == 0) ? full_a : full_b), int'(m_mode[k] == M_FULL));
            idx = 0;
            for (int i = SLOTS - 1; i >= 0; i--)
                if (dn[i] != m_notes[k][i]) idx = i;
            chk($sformatf("%s.notes[%0d]", pfx, idx), int'(dn[idx]), int'(m_notes[k][idx]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        cyc++;
        compare_model();
    endtask

    task automatic clear_pulses();
        rst = 1'b0; start = 1'b0; stop = 1'b0; new_frame = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        clear_pulses();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic       rst, start, stop, nv, nf;
        logic [5:0] note;
        logic [7:0] slot;
        logic       tick, rec, full;
        logic [5:0] n0;
    } vec_t;

    initial begin
        vec_t tbl [13];
        logic [5:0] last_a, last_b;
        int nz, ticks;

        rst = 1'b1; start = 1'b0; stop = 1'b0; note_valid = 1'b0; new_frame = 1'b0; note = '0;
        cycle();
        rst = 1'b0;

`ifndef SCORE_COUNT_IN_EN
        //            rst start stop nv nf note   | slot tick rec full n0
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,6'h00, 8'd0,1'b0,1'b0,1'b0,6'h00};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,6'h21, 8'd0,1'b0,1'b1,1'b0,6'h00};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,6'h21, 8'd0,1'b0,1'b1,1'b0,6'h00};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,6'h21, 8'd0,1'b0,1'b1,1'b0,6'h00};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,6'h21, 8'd0,1'b0,1'b1,1'b0,6'h00};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,6'h21, 8'd1,1'b1,1'b1,1'b0,6'h00};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,6'h00, 8'd1,1'b0,1'b1,1'b0,6'h21};
        tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,6'h00, 8'd1,1'b0,1'b0,1'b0,6'h21};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,6'h00, 8'd1,1'b0,1'b0,1'b0,6'h21};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,6'h00, 8'd1,1'b0,1'b0,1'b0,6'h21};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1,6'h00, 8'd0,1'b0,1'b1,1'b0,6'h21};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,6'h00, 8'd0,1'b0,1'b1,1'b0,6'h00};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,6'h00, 8'd0,1'b0,1'b0,1'b0,6'h00};
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
            note_valid = tbl[i].nv; new_frame = tbl[i].nf; note = tbl[i].note;
            cycle();
            chk($sformatf("tbl%0d.slot", i), int'(slot_a), int'(tbl[i].slot));
            chk($sformatf("tbl%0d.tick", i), int'(tick_a), int'(tbl[i].tick));
            chk($sformatf("tbl%0d.recording", i), int'(rec_a), int'(tbl[i].rec));
            chk($sformatf("tbl%0d.full", i), int'(full_a), int'(tbl[i].full));
            chk($sformatf("tbl%0d.notes0", i), int'(notes_a[0]), int'(tbl[i].n0));
        end
        clear_pulses();

        // Stop coinciding with the tick that would write slot 5.
        do_reset();
        start = 1'b1; note_valid = 1'b1; note = 6'h2A;
        cycle();
        start = 1'b0;
        run(6 * T - 1);
        chk("stop5.slot_before", int'(slot_a), 5);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stop5.slot", int'(slot_a), 5);
        chk("stop5.recording", int'(rec_a), 0);
        note_valid = 1'b0; new_frame = 1'b1;
        cycle();
        new_frame = 1'b0;
        chk("stop5.notes5", int'(notes_a[5]), 0);
        chk("stop5.notes4", int'(notes_a[4]), 'h2A);

        // New frame coinciding with the write of slot 3.
        do_reset();
        start = 1'b1; note_valid = 1'b1; note = 6'h2C;
        cycle();
        start = 1'b0;
        run(4 * T - 1);
        new_frame = 1'b1;
        cycle();
        new_frame = 1'b0;
        chk("frame3.notes3_same", int'(notes_a[3]), 0);
        chk("frame3.notes2", int'(notes_a[2]), 'h2C);
        chk("frame3.slot", int'(slot_a), 4);
        run(2);
        new_frame = 1'b1;
        cycle();
        new_frame = 1'b0;
        chk("frame3.notes3_next", int'(notes_a[3]), 'h2C);

        // Fill the score: one instance stops in FULL, the other wraps.
        do_reset();
        start = 1'b1; note_valid = 1'b1; note = 6'h01;
        cycle();
        start = 1'b0;
        last_a = '0; last_b = '0;
        for (int e = 1; e <= 161 * T; e++) begin
            note = 6'($urandom);
            cycle();
            if (e == 160 * T) begin
                last_a = note;
                chk("fill.full", int'(full_a), 1);
                chk("fill.slot_full", int'(slot_a), 159);
                chk("wrap.slot_at_wrap", int'(slot_b), 0);
                chk("wrap.recording", int'(rec_b), 1);
            end
            if (e == 161 * T) last_b = note;
        end
        chk("wrap.slot_after", int'(slot_b), 1);
        note_valid = 1'b0; new_frame = 1'b1;
        cycle();
        new_frame = 1'b0;
        chk("wrap.entry0", int'(notes_b[0]), int'(last_b));
        nz = 0;
        for (int i = 1; i < SLOTS; i++) if (notes_b[i] != 6'h00) nz++;
        chk("wrap.nonzero_1_159", nz, 0);
        chk("fill.entry159", int'(notes_a[159]), int'(last_a));
        run(20 * T);
        chk("fill.full_held", int'(full_a), 1);
        chk("fill.slot_held", int'(slot_a), 159);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("fill.restart_rec", int'(rec_a), 1);
        chk("fill.restart_slot", int'(slot_a), 0);
        chk("fill.restart_full", int'(full_a), 0);
        new_frame = 1'b1;
        cycle();
        new_frame = 1'b0;
        chk("fill.cleared159", int'(notes_a[159]), 0);
`else
        // Count-in: eight ticks without writes, then record.
        do_reset();
        start = 1'b1; note_valid = 1'b1; note = 6'h33;
        cycle();
        start = 1'b0;
        chk("lead.rec_entry", int'(rec_a), 0);
        ticks = 0;
        for (int e = 1; e <= 8 * T; e++) begin
            cycle();
            if (tick_a) ticks++;
            if (e < 8 * T) chk("lead.rec_low", int'(rec_a), 0);
        end
        chk("lead.ticks", ticks, 8);
        chk("lead.rec_high", int'(rec_a), 1);
        chk("lead.slot0", int'(slot_a), 0);
        run(T - 1);
        chk("lead.no_write_yet", int'(slot_a), 0);
        cycle();
        chk("lead.first_write", int'(slot_a), 1);
        nz = 0; last_a = '0; last_b = '0;
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 599) == 0);
            start      = ($urandom_range(0, 39) == 0);
            stop       = ($urandom_range(0, 299) == 0);
            note_valid = ($urandom_range(0, 2) != 0);
            note       = 6'($urandom);
            new_frame  = ($urandom_range(0, 24) == 0);
            cycle();
        end
        clear_pulses();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
